// File: rtl/stream_pkg.sv
// Shared definitions for the stream pipeline stages.
// Later stream stages add their state enums to this package.
package stream_pkg;

  typedef enum logic [0:0] {
    DS_IDLE = 1'b0,
    DS_BUSY = 1'b1
  } ds_state_e;

endpackage : stream_pkg

// File: rtl/stream_downsizer.sv
// Splits each wide word from the upstream FIFO into up to Ratio narrow beats, lowest slice first.
// Back-to-back words run without bubbles, and flush_i drops the held word together with the FIFO.
module stream_downsizer
  import stream_pkg::*;
#(
  parameter int NarrowWidth = 16,
  parameter int Ratio       = 4,
  localparam int WideWidth  = NarrowWidth * Ratio,
  localparam int LenWidth   = $clog2(Ratio + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   in_vld_i,
  input  logic [WideWidth-1:0]   in_payload_i,
  input  logic [LenWidth-1:0]    in_len_i,
  output logic                   in_rdy_o,
  output logic                   out_vld_o,
  output logic [NarrowWidth-1:0] out_payload_o,
  output logic                   out_last_o,
  input  logic                   out_rdy_i
);

  ds_state_e             state_q, w_state_d;
  logic [WideWidth-1:0]  word_q, w_word_d;
  logic [LenWidth-1:0]   len_q, w_len_d;
  logic [LenWidth-1:0]   idx_q, w_idx_d;

  logic                   w_busy;
  logic                   w_in_fire;
  logic                   w_out_fire;
  logic [LenWidth-1:0]    w_len_eff;
  logic [NarrowWidth-1:0] w_slice;

  assign w_busy = (state_q == DS_BUSY);

  // Lengths above Ratio are clamped so idx_q never walks past the last slice.
  assign w_len_eff = (in_len_i > LenWidth'(Ratio)) ? LenWidth'(Ratio) : in_len_i;

  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    w_slice = '0;
    for (int k = 0; k < Ratio; k++) begin
      if (idx_q == LenWidth'(k)) w_slice = word_q[k*NarrowWidth +: NarrowWidth];
    end
  end

  assign out_vld_o     = w_busy;
  assign out_payload_o = w_busy ? w_slice : '0;
  assign out_last_o    = w_busy & (idx_q == (len_q - LenWidth'(1)));

  // Combinational out_rdy_i -> in_rdy_o lets a new word load on the last beat with no bubble.
  assign in_rdy_o   = !rst & !flush_i & (!w_busy | (out_last_o & out_rdy_i));
  assign w_in_fire  = in_vld_i & in_rdy_o;
  assign w_out_fire = out_vld_o & out_rdy_i;

  always_comb begin
    w_state_d = state_q;
    w_word_d  = word_q;
    w_len_d   = len_q;
    w_idx_d   = idx_q;

    if (flush_i) begin
      w_state_d = DS_IDLE;
      w_idx_d   = '0;
    end else begin
      if (w_out_fire) begin
        if (out_last_o) w_state_d = DS_IDLE;
        else            w_idx_d   = idx_q + LenWidth'(1);
      end
      // A zero-length word is consumed without touching the held state.
      if (w_in_fire && (w_len_eff != '0)) begin
        w_word_d  = in_payload_i;
        w_len_d   = w_len_eff;
        w_idx_d   = '0;
        w_state_d = DS_BUSY;
      end
    end
  end

  // NOTE: word_q is a plain datapath register, so it is reset along with the control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DS_IDLE;
      word_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state_q <= w_state_d;
      word_q  <= w_word_d;
      len_q   <= w_len_d;
      idx_q   <= w_idx_d;
    end
  end

endmodule : stream_downsizer
